ex_pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the EX stage and its EX/MEM latch.
- Produces forwarding selects for both ALU operands and detects load-use hazards.
- Sequences a multi-cycle EX operation (multiply) by freezing the front of the pipe for a programmed number of cycles.
- Handles branch-taken flushes from MEM; keeps a saturating stall-cycle counter for performance debug.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/ex_pipe_ctrl_if.sv | 55 +++++
 rtl/ex_fwd_unit.sv | 24 ++
 rtl/ex_pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_ex_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the EX-stage pipeline control.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // EX/MEM wins over MEM/WB because it carries the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             exmem_regwrite,
        input logic [REG_W-1:0] exmem_rd,
        input logic             memwb_regwrite,
        input logic [REG_W-1:0] memwb_rd
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src)) begin
            sel = FWD_MEM;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pipe_ctrl_if
//  Description : Hazard-detection inputs and pipeline-control outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic             idex_memread;
    logic             ex_mul;
    logic             exmem_regwrite;
    logic [REG_W-1:0] exmem_rd;
    logic             memwb_regwrite;
    logic [REG_W-1:0] memwb_rd;
    logic             mem_branch;
    logic             mem_zero;

    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             ifid_flush;
    logic             pcsrc;
    logic             mul_busy;
    logic             mul_done;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, idex_rs, idex_rt, idex_memread, ex_mul,
               exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd,
               mem_branch, mem_zero,
        input  fwd_a, fwd_b, pc_write, ifid_write, idex_write, idex_bubble,
               exmem_bubble, ifid_flush, pcsrc, mul_busy, mul_done, stall_count
    );

    modport slave (
        input  id_rs, id_rt, idex_rs, idex_rt, idex_memread, ex_mul,
               exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd,
               mem_branch, mem_zero,
        output fwd_a, fwd_b, pc_write, ifid_write, idex_write, idex_bubble,
               exmem_bubble, ifid_flush, pcsrc, mul_busy, mul_done, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/ex_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_fwd_unit
//  Description : Combinational ALU operand forwarding selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_fwd_unit
    import cpu_pkg::*;
(
    input  wire logic [REG_W-1:0] idex_rs,
    input  wire logic [REG_W-1:0] idex_rt,
    input  wire logic             exmem_regwrite,
    input  wire logic [REG_W-1:0] exmem_rd,
    input  wire logic             memwb_regwrite,
    input  wire logic [REG_W-1:0] memwb_rd,
    output logic      [1:0]       fwd_a,
    output logic      [1:0]       fwd_b
);

    assign fwd_a = fwd_sel(idex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    assign fwd_b = fwd_sel(idex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);

endmodule
`default_nettype wire

// File: rtl/ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pipe_ctrl
//  Description : EX-stage sequencing: forwarding, load-use stall, multi-cycle
//                op hold, branch flush and saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
)(
    input  wire logic    clk,
    input  wire logic    rst,
    ex_pipe_ctrl_if.slave bus
);

    localparam logic [3:0] c_CNT_LOAD = 4'(MUL_CYCLES - 2);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_take;
    logic       w_lu;
    logic       w_hold;
    logic       w_done;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_idex_write;
    logic       w_idex_bubble;
    logic       w_exmem_bubble;
    logic       w_ifid_flush;
    logic       w_pcsrc;

    ex_fwd_unit u_fwd (
        .idex_rs        (bus.idex_rs),
        .idex_rt        (bus.idex_rt),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_rd       (bus.exmem_rd),
        .memwb_regwrite (bus.memwb_regwrite),
        .memwb_rd       (bus.memwb_rd),
        .fwd_a          (w_fwd_a),
        .fwd_b          (w_fwd_b)
    );

    assign w_take = bus.mem_branch & bus.mem_zero;
    assign w_lu   = bus.idex_memread && (bus.idex_rt != '0) &&
                    ((bus.idex_rt == bus.id_rs) || (bus.idex_rt == bus.id_rt));
    assign w_hold = ((r_state == ST_IDLE) && bus.ex_mul) ||
                    ((r_state == ST_BUSY) && (r_cnt != 4'd0));
    assign w_done = rst && !w_take && (r_state == ST_BUSY) && (r_cnt == 4'd0);

    // Outputs are forced to their idle values while reset is asserted.
    always_comb begin
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_idex_write   = 1'b1;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;
        w_ifid_flush   = 1'b0;
        w_pcsrc        = 1'b0;
        if (rst) begin
            if (w_take) begin
                w_pcsrc        = 1'b1;
                w_ifid_flush   = 1'b1;
                w_idex_bubble  = 1'b1;
                w_exmem_bubble = 1'b1;
            end else if (w_hold) begin
                w_pc_write     = 1'b0;
                w_ifid_write   = 1'b0;
                w_idex_write   = 1'b0;
                w_exmem_bubble = 1'b1;
            end else if (w_lu) begin
                w_pc_write     = 1'b0;
                w_ifid_write   = 1'b0;
                w_idex_bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_stall_count <= '0;
        end else begin
            if (w_take) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.ex_mul) begin
                            r_state <= ST_BUSY;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                    ST_BUSY: begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (!w_pc_write && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_a        = rst ? w_fwd_a : FWD_REG;
    assign bus.fwd_b        = rst ? w_fwd_b : FWD_REG;
    assign bus.pc_write     = w_pc_write;
    assign bus.ifid_write   = w_ifid_write;
    assign bus.idex_write   = w_idex_write;
    assign bus.idex_bubble  = w_idex_bubble;
    assign bus.exmem_bubble = w_exmem_bubble;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.pcsrc        = w_pcsrc;
    assign bus.mul_busy     = (r_state == ST_BUSY);
    assign bus.mul_done     = w_done;
    assign bus.stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_pipe_ctrl
//  Description : Directed self-checking bench for ex_pipe_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_pipe_ctrl;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    ex_pipe_ctrl_if #(.CNT_W(16)) bus0 ();
    ex_pipe_ctrl_if #(.CNT_W(4))  bus1 ();

    ex_pipe_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ex_pipe_ctrl #(.MUL_CYCLES(2), .CNT_W(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ew;
        logic [4:0] er;
        logic       mw;
        logic [4:0] mr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } fwd_vec_t;

    fwd_vec_t fv [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear0;
        bus0.id_rs = '0; bus0.id_rt = '0; bus0.idex_rs = '0; bus0.idex_rt = '0;
        bus0.idex_memread = 1'b0; bus0.ex_mul = 1'b0;
        bus0.exmem_regwrite = 1'b0; bus0.exmem_rd = '0;
        bus0.memwb_regwrite = 1'b0; bus0.memwb_rd = '0;
        bus0.mem_branch = 1'b0; bus0.mem_zero = 1'b0;
    endtask

    task automatic clear1;
        bus1.id_rs = '0; bus1.id_rt = '0; bus1.idex_rs = '0; bus1.idex_rt = '0;
        bus1.idex_memread = 1'b0; bus1.ex_mul = 1'b0;
        bus1.exmem_regwrite = 1'b0; bus1.exmem_rd = '0;
        bus1.memwb_regwrite = 1'b0; bus1.memwb_rd = '0;
        bus1.mem_branch = 1'b0; bus1.mem_zero = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        fv[0] = '{1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  5'd5, 2'b10, 2'b10};
        fv[1] = '{1'b1, 5'd0,  1'b1, 5'd5,  5'd5,  5'd5, 2'b01, 2'b01};
        fv[2] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd5,  5'd5, 2'b00, 2'b00};
        fv[3] = '{1'b1, 5'd3,  1'b1, 5'd4,  5'd3,  5'd4, 2'b10, 2'b01};
        fv[4] = '{1'b0, 5'd3,  1'b1, 5'd3,  5'd3,  5'd9, 2'b01, 2'b00};
        fv[5] = '{1'b1, 5'd9,  1'b0, 5'd9,  5'd1,  5'd9, 2'b00, 2'b10};
        fv[6] = '{1'b0, 5'd6,  1'b0, 5'd6,  5'd6,  5'd6, 2'b00, 2'b00};
        fv[7] = '{1'b1, 5'd31, 1'b1, 5'd31, 5'd31, 5'd0, 2'b10, 2'b00};

        clear0();
        clear1();
        rst = 1'b0;

        // Reset held: outputs idle even with forwarding and mul requests present.
        bus0.exmem_regwrite = 1'b1; bus0.exmem_rd = 5'd5; bus0.idex_rs = 5'd5;
        bus0.ex_mul = 1'b1;
        #2;
        chk("rst_fwd_a",    32'(bus0.fwd_a), 32'h0);
        chk("rst_pc_write", 32'(bus0.pc_write), 32'h1);
        chk("rst_ifid_wr",  32'(bus0.ifid_write), 32'h1);
        chk("rst_exmem_bb", 32'(bus0.exmem_bubble), 32'h0);
        chk("rst_busy",     32'(bus0.mul_busy), 32'h0);
        chk("rst_count",    32'(bus0.stall_count), 32'h0);
        next_cycle();
        clear0();
        #2;
        rst = 1'b1;

        // Forwarding table
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            bus0.exmem_regwrite = fv[i].ew; bus0.exmem_rd = fv[i].er;
            bus0.memwb_regwrite = fv[i].mw; bus0.memwb_rd = fv[i].mr;
            bus0.idex_rs = fv[i].rs; bus0.idex_rt = fv[i].rt;
            #2;
            chk($sformatf("fwd_a[%0d]", i), 32'(bus0.fwd_a), 32'(fv[i].exp_a));
            chk($sformatf("fwd_b[%0d]", i), 32'(bus0.fwd_b), 32'(fv[i].exp_b));
            chk($sformatf("fwd_pcw[%0d]", i), 32'(bus0.pc_write), 32'h1);
        end
        next_cycle();
        clear0();

        // Load-use, one cycle
        next_cycle();
        bus0.idex_memread = 1'b1; bus0.idex_rt = 5'd7; bus0.id_rs = 5'd7;
        #2;
        chk("lu_pc_write",  32'(bus0.pc_write), 32'h0);
        chk("lu_ifid_wr",   32'(bus0.ifid_write), 32'h0);
        chk("lu_idex_bb",   32'(bus0.idex_bubble), 32'h1);
        chk("lu_idex_wr",   32'(bus0.idex_write), 32'h1);
        next_cycle();
        clear0();
        #2;
        chk("lu_after_pcw", 32'(bus0.pc_write), 32'h1);
        chk("lu_after_bb",  32'(bus0.idex_bubble), 32'h0);
        chk("lu_count",     32'(bus0.stall_count), 32'd1);

        // Two back-to-back multi-cycle ops
        for (int k = 1; k <= 8; k++) begin
            int ph;
            ph = ((k - 1) % 4) + 1;
            next_cycle();
            bus0.ex_mul = 1'b1;
            #2;
            chk($sformatf("mul_pcw[%0d]", k),  32'(bus0.pc_write), (ph < 4) ? 32'h0 : 32'h1);
            chk($sformatf("mul_exbb[%0d]", k), 32'(bus0.exmem_bubble), (ph < 4) ? 32'h1 : 32'h0);
            chk($sformatf("mul_busy[%0d]", k), 32'(bus0.mul_busy), (ph >= 2) ? 32'h1 : 32'h0);
            chk($sformatf("mul_done[%0d]", k), 32'(bus0.mul_done), (ph == 4) ? 32'h1 : 32'h0);
        end
        next_cycle();
        clear0();
        #2;
        chk("mul_count", 32'(bus0.stall_count), 32'd7);
        chk("mul_idle",  32'(bus0.mul_busy), 32'h0);

        // Branch taken on cycle 2 of a multi-cycle op
        next_cycle();
        bus0.ex_mul = 1'b1;
        next_cycle();
        bus0.mem_branch = 1'b1; bus0.mem_zero = 1'b1;
        bus0.exmem_regwrite = 1'b1; bus0.exmem_rd = 5'd5; bus0.idex_rs = 5'd5;
        #2;
        chk("br_pcsrc",   32'(bus0.pcsrc), 32'h1);
        chk("br_flush",   32'(bus0.ifid_flush), 32'h1);
        chk("br_idex_bb", 32'(bus0.idex_bubble), 32'h1);
        chk("br_exbb",    32'(bus0.exmem_bubble), 32'h1);
        chk("br_pcw",     32'(bus0.pc_write), 32'h1);
        chk("br_idex_wr", 32'(bus0.idex_write), 32'h1);
        chk("br_done",    32'(bus0.mul_done), 32'h0);
        chk("br_fwd_a",   32'(bus0.fwd_a), 32'h2);
        next_cycle();
        clear0();
        #2;
        chk("br_idle",    32'(bus0.mul_busy), 32'h0);
        chk("br_done2",   32'(bus0.mul_done), 32'h0);
        chk("br_pcsrc2",  32'(bus0.pcsrc), 32'h0);
        chk("br_count",   32'(bus0.stall_count), 32'd8);

        // Load-use while held by a multi-cycle op
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            bus0.ex_mul = 1'b1;
            bus0.idex_memread = 1'b1; bus0.idex_rt = 5'd4; bus0.id_rt = 5'd4;
            #2;
            chk($sformatf("luh_bb[%0d]", k),  32'(bus0.idex_bubble), (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("luh_pcw[%0d]", k), 32'(bus0.pc_write), 32'h0);
        end
        next_cycle();
        clear0();
        #2;
        chk("luh_bb_after", 32'(bus0.idex_bubble), 32'h0);
        chk("luh_count",    32'(bus0.stall_count), 32'd12);

        // Asynchronous reset in the middle of BUSY
        next_cycle();
        bus0.ex_mul = 1'b1;
        next_cycle();
        #1;
        rst = 1'b0;
        #1;
        chk("arst_pcw",   32'(bus0.pc_write), 32'h1);
        chk("arst_busy",  32'(bus0.mul_busy), 32'h0);
        chk("arst_exbb",  32'(bus0.exmem_bubble), 32'h0);
        chk("arst_count", 32'(bus0.stall_count), 32'h0);
        next_cycle();
        clear0();
        rst = 1'b1;
        next_cycle();
        #2;
        chk("arst_count2", 32'(bus0.stall_count), 32'h0);

        // MUL_CYCLES=2 instance: one hold cycle then done
        next_cycle();
        bus1.ex_mul = 1'b1;
        #2;
        chk("m2_pcw1",  32'(bus1.pc_write), 32'h0);
        chk("m2_done1", 32'(bus1.mul_done), 32'h0);
        next_cycle();
        #2;
        chk("m2_pcw2",  32'(bus1.pc_write), 32'h1);
        chk("m2_done2", 32'(bus1.mul_done), 32'h1);
        chk("m2_busy2", 32'(bus1.mul_busy), 32'h1);
        next_cycle();
        clear1();
        #2;
        chk("m2_count", 32'(bus1.stall_count), 32'd1);

        // Continuous stall saturates the 4-bit counter
        bus1.idex_memread = 1'b1; bus1.idex_rt = 5'd3; bus1.id_rt = 5'd3;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            #2;
            if (i == 10) chk("sat_mid", 32'(bus1.stall_count), 32'd11);
        end
        chk("sat_end", 32'(bus1.stall_count), 32'd15);
        clear1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
